uart_tx: RTL and testbench

UART transmitter for the pipelined CPU's serial peripheral, the transmit-side counterpart of the existing receive path on `uart_rxd`. It accepts bytes over a valid/ready handshake into a small FIFO and serializes each one onto `uart_txd` as 8N1 by default, LSB first, at a fixed baud rate derived from the system clock. It sits between the CPU's memory-mapped UART registers and the board `uart_txd` pin. It also serves as the bench-side byte source for loopback tests.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_fifo.sv | 35 +++
 rtl/uart_tx.sv | 98 +++++++++
 tb/tb_uart_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and defaults; UART_TX_PARITY_EN selects the 11-bit frame
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int UART_CLK_HZ = 50_000_000;
  localparam int UART_BAUD = 9600;
`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
`else
  localparam int UART_FRAME_BITS = 10;
`endif
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with extra-bit pointers so full and empty differ at wrap-around
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = wr_ptr == rd_ptr;
  assign dout = mem[rd_ptr[AW-1:0]];
  // storage write; a push while full is dropped even if a pop happens in the same cycle
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  // pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = UART_CLK_HZ,
  parameter int BAUD = UART_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW = $clog2(DIV);
  localparam logic [BW-1:0] LAST = BW'(DIV - 1);
  uart_tx_state_t state, state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, head;
  logic full, empty, pop, bit_end, line;
  assign bit_end = baud_cnt == LAST;
  assign tx_ready = !full;
  assign tx_busy = state != IDLE || !empty;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(tx_valid && tx_ready),
    .pop(pop),
    .din(tx_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  // next state: each non-idle state lasts one bit period; STOP chains straight into START when data waits
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = empty ? IDLE : START;
      START:   if (bit_end) state_next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:    if (bit_end && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (bit_end) state_next = STOP;
`else
      DATA:    if (bit_end && bit_cnt == 3'd7) state_next = STOP;
`endif
      STOP:    if (bit_end) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end
`ifdef UART_TX_PARITY_EN
  logic par_bit;
  // even parity latched from the byte as it leaves the FIFO
  always_ff @(posedge clk)
    par_bit <= reset ? 1'b0 : pop ? ^head : par_bit;
`endif
  // outputs: pop on every entry into START, line level from the current state
  always_comb begin
    pop = !empty && (state == IDLE || (state == STOP && bit_end));
`ifdef UART_TX_PARITY_EN
    line = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_bit : 1'b1;
`else
    line = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
  end
  // datapath: registered line, baud counter, bit counter and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_txd <= 1'b1;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
    end else begin
      uart_txd <= line;
      if (pop) begin
        baud_cnt <= '0;
        bit_cnt <= '0;
        shift <= head;
      end else if (state == IDLE) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end && state == DATA) begin
          shift <= shift >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench with a frame-decoding scoreboard for uart_tx
module tb_uart_tx;
  localparam int DIV = 10;
  localparam int D_DIV = 5208;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] tx_data = '0, d_data = '0;
  logic tx_valid = 1'b0, d_valid = 1'b0;
  logic tx_ready, txd, tx_busy, d_ready, d_txd, d_busy;
  logic [2:0] fifo_count, d_count;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic mon_en = 1'b0;
  int exp_q[$];
  int starts[$];
  logic [7:0] m_b;
  int m_e;

  uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .uart_txd(txd), .tx_busy(tx_busy), .fifo_count(fifo_count));
  uart_tx d_dut (
    .clk(clk), .reset(reset), .tx_data(d_data), .tx_valid(d_valid), .tx_ready(d_ready),
    .uart_txd(d_txd), .tx_busy(d_busy), .fifo_count(d_count));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit track, output int t);
    int n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) chk("push_timeout", n, 0);
    @(posedge clk); #1;
    t = cyc;
    tx_valid = 1'b0;
    if (track) exp_q.push_back(b);
  endtask

  task automatic wait_fall(output int f);
    int n = 0;
    while (txd !== 1'b0 && n < 1000) begin
      @(negedge clk); n++;
    end
    if (n >= 1000) chk("fall_timeout", n, 0);
    f = cyc;
  endtask

  task automatic run(input bit dflt, input logic lvl, output int n);
    n = 0;
    while (((dflt ? d_txd : txd) === lvl) && n < 60000) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) chk("idle_timeout", n, 0);
  endtask

  // scoreboard: decode each frame at mid-bit and compare with the oldest pushed byte
  initial forever begin
    @(negedge clk);
    if (mon_en && !reset && txd === 1'b0) begin
      starts.push_back(cyc);
      repeat (DIV / 2) @(negedge clk);
      chk("start_bit", txd, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        m_b[i] = txd;
      end
`ifdef UART_TX_PARITY_EN
      repeat (DIV) @(negedge clk);
      chk("parity_bit", txd, ^m_b);
`endif
      repeat (DIV) @(negedge clk);
      chk("stop_bit", txd, 1);
      m_e = exp_q.size() != 0 ? exp_q.pop_front() : -1;
      chk("frame_byte", m_b, m_e);
    end
  end

  initial begin
    int t, t6, f, n;
    // reset and idle
    @(posedge clk); #1;
    chk("reset_vals", {txd, tx_ready, tx_busy, fifo_count}, {1'b1, 1'b1, 1'b0, 3'd0});
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_vals", {txd, tx_ready, tx_busy, fifo_count, d_txd, d_busy},
          {1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0});
    end
    // single byte 0x0F: latency, level run lengths, frame length
    mon_en = 1'b1;
    @(posedge clk); #1;
    push(8'h0F, 1, t);
    wait_fall(f);
    chk("first_fall_latency", f - t, 2);
    run(0, 1'b0, n);
    chk("run_start", n, DIV);
    run(0, 1'b1, n);
    chk("run_bits0_3", n, 4 * DIV);
    run(0, 1'b0, n);
    chk("run_bits4_7", n, (FRAME - 6) * DIV);
    n = 0;
    while (tx_busy !== 1'b0 && n < 1000) begin
      @(negedge clk); n++;
    end
    chk("frame_len", cyc - f + 1, FRAME * DIV);
    wait_idle();
    push(8'h07, 1, t);
    wait_idle();
    // back-to-back: four pushes fill the FIFO, the sixth stalls until the next pop
    starts.delete();
    push(8'h0F, 1, t);
    push(8'h14, 1, t);
    push(8'hA5, 1, t);
    push(8'h3C, 1, t);
    push(8'hFF, 1, t);
    chk("full_count", fifo_count, 4);
    chk("full_ready", tx_ready, 0);
    push(8'h81, 1, t6);
    chk("stall_release", t6 - starts[0], FRAME * DIV);
    wait_idle();
    chk("frame_total", starts.size(), 6);
    for (int i = 1; i < 6 && i < starts.size(); i++)
      chk("start_spacing", starts[i] - starts[i-1], FRAME * DIV);
    // reset during data bit 3 of 0xA5 with two bytes queued
    mon_en = 1'b0;
    repeat (5) @(posedge clk); #1;
    push(8'hA5, 0, t);
    push(8'h11, 0, t);
    push(8'h22, 0, t);
    wait_fall(f);
    chk("queued_count", fifo_count, 2);
    while (cyc < f + 4 * DIV + DIV / 2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_vals", {txd, tx_ready, tx_busy, fifo_count}, {1'b1, 1'b1, 1'b0, 3'd0});
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 50 * DIV; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) n++;
    end
    chk("no_restart", n, 0);
    // full-rate timing on the default build: 0x14 gives runs of 3,1,1,1,3 bits
    @(posedge clk); #1;
    d_data = 8'h14;
    d_valid = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    d_valid = 1'b0;
    n = 0;
    while (d_txd !== 1'b0 && n < 100) begin
      @(negedge clk); n++;
    end
    f = cyc;
    chk("d_fall_latency", f - t, 2);
    run(1, 1'b0, n);
    chk("d_run_start_b0_b1", n, 3 * D_DIV);
    run(1, 1'b1, n);
    chk("d_run_b2", n, D_DIV);
    run(1, 1'b0, n);
    chk("d_run_b3", n, D_DIV);
    run(1, 1'b1, n);
    chk("d_run_b4", n, D_DIV);
    run(1, 1'b0, n);
    chk("d_run_b5_b7", n, (FRAME - 7) * D_DIV);
    n = 0;
    while (d_busy !== 1'b0 && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("d_frame_len", cyc - f + 1, FRAME * D_DIV);
    chk("d_idle_line", d_txd, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
